// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, state/column widths and the iterative-unit FSM encoding.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_e;

  // Element [3] is the most significant word, which is column 0.
  typedef logic [3:0][AES_COL_W-1:0] state_cols_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Forward MixColumns on one 32-bit column; row 0 is the most significant byte.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  output logic [AES_COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a is expressed as xtime(a) ^ a.
  assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: COLS_PER_CYCLE columns per BUSY cycle, with a pass-through
// bypass for the final round that keeps the same latency.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_state_e  state_reg;
  state_cols_t work_reg;
  state_cols_t work_next;
  logic        bypass_reg;
  logic [1:0]  col_cnt_reg;
  logic        out_valid_reg;

  logic [1:0]           col_idx [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_out [COLS_PER_CYCLE];

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    assign col_idx[gi] = col_cnt_reg + 2'(gi);
    assign col_in[gi]  = work_reg[2'd3 - col_idx[gi]];

    mix_column_word u_mix (
      .col_in  (col_in[gi]),
      .col_out (col_out[gi])
    );
  end

  always_comb begin
    work_next = work_reg;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_next[2'd3 - col_idx[k]] = bypass_reg ? col_in[k] : col_out[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      bypass_reg    <= 1'b0;
      col_cnt_reg   <= 2'd0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg    <= in_state;
            bypass_reg  <= in_bypass;
            col_cnt_reg <= 2'd0;
            state_reg   <= BUSY;
          end
        end
        BUSY: begin
          work_reg    <= work_next;
          col_cnt_reg <= col_cnt_reg + STEP;
          // This edge writes column 3, so the result is complete.
          if (col_cnt_reg == LAST_CNT) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_state = work_reg;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle) driven from
// a shared vector table, plus backpressure, mid-operation reset and back-to-back sequences.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         in_valid_v  [3];
  logic         out_ready_v [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic [127:0] out_state_w [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_w[gi]),
      .in_state  (in_state),
      .in_bypass (in_bypass),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready_v[gi]),
      .out_state (out_state_w[gi])
    );
  end

  typedef struct {
    string        name;
    logic [127:0] st;
    logic         byp;
    logic [127:0] exp;
    int           hold;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply used by the reference model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
      r[103-32*c -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
    end
    return r;
  endfunction

  // One transaction on all three instances; checks latency, data, optional hold and release.
  task automatic run_vec(input vec_t v);
    int  lat [3];
    logic bp_bad [3];
    @(negedge clk);
    in_state  = v.st;
    in_bypass = v.byp;
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0;
      lat[i] = 0;
      bp_bad[i] = 1'b0;
    end
    in_state  = ~v.st;
    in_bypass = ~v.byp;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (out_valid_w[i] && lat[i] == 0) lat[i] = c;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s lat c%0d", v.name, 1 << i), 128'(lat[i]), 128'(4 >> i));
      check($sformatf("%s data c%0d", v.name, 1 << i), out_state_w[i], v.exp);
    end
    for (int h = 0; h < v.hold; h++) begin
      for (int i = 0; i < 3; i++) in_valid_v[i] = h[0];
      in_state = 128'(h) * 128'h0123_4567;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (!out_valid_w[i] || in_ready_w[i] || out_state_w[i] !== v.exp) bp_bad[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    if (v.hold > 0)
      for (int i = 0; i < 3; i++)
        check($sformatf("%s hold_stable c%0d", v.name, 1 << i), 128'(bp_bad[i]), 128'd0);
    for (int i = 0; i < 3; i++) out_ready_v[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      out_ready_v[i] = 1'b0;
      check($sformatf("%s release c%0d", v.name, 1 << i),
            {126'd0, out_valid_w[i], in_ready_w[i]}, 128'b01);
    end
  endtask

  // Three states streamed through instance i with both handshakes held open.
  task automatic back_to_back(input int i);
    logic [127:0] s [3];
    int na = 0, nd = 0, cyc = 0, last_acc = 0;
    for (int k = 0; k < 3; k++) s[k] = {$urandom, $urandom, $urandom, $urandom};
    in_bypass = 1'b0;
    out_ready_v[i] = 1'b1;
    while ((na < 3 || nd < 3) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (na < 3) begin
        in_state = s[na];
        in_valid_v[i] = 1'b1;
      end else begin
        in_valid_v[i] = 1'b0;
      end
      if (out_valid_w[i] && nd < 3) begin
        check($sformatf("b2b data c%0d #%0d", 1 << i, nd), out_state_w[i], model(s[nd]));
        nd++;
      end
      if (in_ready_w[i] && in_valid_v[i]) begin
        if (na > 0)
          check($sformatf("b2b spacing c%0d #%0d", 1 << i, na), 128'(cyc - last_acc),
                128'((4 >> i) + 2));
        last_acc = cyc;
        na++;
      end
    end
    in_valid_v[i]  = 1'b0;
    out_ready_v[i] = 1'b0;
    check($sformatf("b2b complete c%0d", 1 << i), 128'(na * 4 + nd), 128'(3 * 4 + 3));
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    vec_t vecs [7];
    vecs[0] = '{"fips_r1",  FIPS_IN, 1'b0, FIPS_OUT, 0};
    vecs[1] = '{"col2_db",  {64'd0, 32'hdb135345, 32'd0}, 1'b0, {64'd0, 32'h8e4da1bc, 32'd0}, 0};
    vecs[2] = '{"col2_f2",  {64'd0, 32'hf20a225c, 32'd0}, 1'b0, {64'd0, 32'h9fdc589d, 32'd0}, 0};
    vecs[3] = '{"col2_c6",  {64'd0, 32'hc6c6c6c6, 32'd0}, 1'b0, {64'd0, 32'hc6c6c6c6, 32'd0}, 0};
    vecs[4] = '{"col2_2d",  {64'd0, 32'h2d26314c, 32'd0}, 1'b0, {64'd0, 32'h4d7ebdf8, 32'd0}, 0};
    vecs[5] = '{"bypass",   128'h00112233445566778899aabbccddeeff, 1'b1,
                128'h00112233445566778899aabbccddeeff, 0};
    vecs[6] = '{"backpress", FIPS_IN, 1'b0, FIPS_OUT, 10};

    rst_n = 1'b0;
    in_state = '0;
    in_bypass = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset c%0d", 1 << i),
            {out_state_w[i], out_valid_w[i], in_ready_w[i]}, {128'd0, 1'b0, 1'b1});
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Reset two edges after accept: the 1-column instance is mid-BUSY, the others in DONE.
    @(negedge clk);
    in_state = FIPS_IN;
    in_bypass = 1'b0;
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("midreset c%0d", 1 << i),
            {out_state_w[i], out_valid_w[i], in_ready_w[i]}, {128'd0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    for (int i = 0; i < 3; i++) back_to_back(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
